// File: rtl/nibble_check_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nibble_check_pkg: state encodings, mask constant and successor helper |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package nibble_check_pkg;

   localparam int NIBBLE_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_HUNT   = 2'd0;
   localparam state_t ST_SYNC   = 2'd1;
   localparam state_t ST_LOCKED = 2'd2;

   localparam logic [NIBBLE_W-1:0] NIBBLE_MASK = 4'b0111;

   // Next value of the masked incrementing sequence; the mask gives the wrap.
   function automatic logic [NIBBLE_W-1:0] succ(input logic [NIBBLE_W-1:0] x,
                                                input logic [NIBBLE_W-1:0] mask);
      return (x + 4'd1) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sat_counter: increment-on-strobe counter that sticks at all-ones      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/nibble_seq_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nibble_seq_checker: locks onto a masked incrementing nibble stream    |
// | and flags every deviation once locked.   Revision: 1.0                |
// +-----------------------------------------------------------------------+
module nibble_seq_checker
   import nibble_check_pkg::*;
#(
   parameter int               WIDTH      = 4,
   parameter logic [WIDTH-1:0] MASK       = NIBBLE_MASK,
   parameter int               LOCK_COUNT = 4,
   parameter int               LOSS_COUNT = 2,
   parameter int               ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             locked,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
);

   localparam int c_run_w  = $clog2(LOCK_COUNT + 1);
   localparam int c_miss_w = $clog2(LOSS_COUNT + 1);

   localparam logic [c_run_w-1:0]  c_run_last  = c_run_w'(LOCK_COUNT - 1);
   localparam logic [c_miss_w-1:0] c_miss_last = c_miss_w'(LOSS_COUNT - 1);
   localparam logic [WIDTH-1:0]    c_one       = WIDTH'(1);

   function automatic logic [WIDTH-1:0] f_succ(input logic [WIDTH-1:0] x);
      return (x + c_one) & MASK;
   endfunction

   state_t              r_state;
   logic [WIDTH-1:0]    r_ref;
   logic [c_run_w-1:0]  r_run;
   logic [c_miss_w-1:0] r_miss;
   logic                r_locked;
   logic                r_mismatch;
   logic [WIDTH-1:0]    r_expected;

   state_t              w_state_nxt;
   logic [WIDTH-1:0]    w_ref_nxt;
   logic [c_run_w-1:0]  w_run_nxt;
   logic [c_miss_w-1:0] w_miss_nxt;
   logic                w_bad;
   logic                w_locked_nxt;
   logic                w_mismatch_nxt;
   logic [WIDTH-1:0]    w_expected_nxt;

   logic                w_stray;
   logic                w_good;
   logic [WIDTH-1:0]    w_succ_ref;

   assign w_succ_ref = f_succ(r_ref);
   assign w_stray    = (in_data & ~MASK) != '0;
   assign w_good     = !w_stray && (in_data == w_succ_ref);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_HUNT;
         r_ref      <= '0;
         r_run      <= '0;
         r_miss     <= '0;
         r_locked   <= 1'b0;
         r_mismatch <= 1'b0;
         r_expected <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ref      <= w_ref_nxt;
         r_run      <= w_run_nxt;
         r_miss     <= w_miss_nxt;
         r_locked   <= w_locked_nxt;
         r_mismatch <= w_mismatch_nxt;
         r_expected <= w_expected_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ref_nxt   = r_ref;
      w_run_nxt   = r_run;
      w_miss_nxt  = r_miss;
      w_bad       = 1'b0;
      if (in_valid) begin
         case (r_state)
            ST_HUNT: begin
               if (!w_stray) begin
                  w_ref_nxt   = in_data;
                  w_run_nxt   = '0;
                  w_state_nxt = ST_SYNC;
               end
            end
            ST_SYNC: begin
               if (w_stray) begin
                  w_run_nxt   = '0;
                  w_state_nxt = ST_HUNT;
               end else if (w_good) begin
                  w_ref_nxt = in_data;
                  w_run_nxt = r_run + c_run_w'(1);
                  if (r_run == c_run_last) begin
                     w_state_nxt = ST_LOCKED;
                  end
               end else begin
                  w_ref_nxt = in_data;
                  w_run_nxt = '0;
               end
            end
            ST_LOCKED: begin
               if (w_good) begin
                  w_ref_nxt  = in_data;
                  w_miss_nxt = '0;
               end else begin
                  // Flywheel: keep predicting from our own sequence, not the bad data.
                  w_bad     = 1'b1;
                  w_ref_nxt = w_succ_ref;
                  if (r_miss == c_miss_last) begin
                     w_miss_nxt  = '0;
                     w_run_nxt   = '0;
                     w_state_nxt = ST_HUNT;
                  end else begin
                     w_miss_nxt = r_miss + c_miss_w'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = ST_HUNT;
            end
         endcase
      end
   end

   always_comb begin
      w_locked_nxt   = (w_state_nxt == ST_LOCKED);
      w_mismatch_nxt = w_bad;
      w_expected_nxt = '0;
      if ((w_state_nxt == ST_SYNC) || (w_state_nxt == ST_LOCKED)) begin
         w_expected_nxt = f_succ(w_ref_nxt);
      end
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_bad),
      .count (err_count)
   );

   assign locked   = r_locked;
   assign mismatch = r_mismatch;
   assign expected = r_expected;

endmodule
`default_nettype wire

// File: tb/tb_nibble_seq_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_nibble_seq_checker: directed scenarios against a sequence model    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_nibble_seq_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'd0;

   logic       a_locked, a_mismatch, b_locked, b_mismatch;
   logic [7:0] a_err;
   logic [1:0] b_err;
   logic [3:0] a_expected, b_expected;

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;

   // Reference model state: plain integers, seeded/locked flags.
   int  m_ref, m_run, m_miss, m_err;
   bit  m_seeded, m_locked, m_mism;

   always #5 clk = ~clk;

   nibble_seq_checker dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .locked    (a_locked),
      .mismatch  (a_mismatch),
      .err_count (a_err),
      .expected  (a_expected)
   );

   nibble_seq_checker #(.ERR_W(2)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .locked    (b_locked),
      .mismatch  (b_mismatch),
      .err_count (b_err),
      .expected  (b_expected)
   );

   function automatic int nxt(input int x);
      return (x + 1) % 8;
   endfunction

   function automatic int m_expected();
      return (m_seeded || m_locked) ? nxt(m_ref) : 0;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input int d);
      automatic bit stray;
      automatic bit good;
      m_mism = 1'b0;
      if (r) begin
         m_ref = 0; m_run = 0; m_miss = 0; m_err = 0;
         m_seeded = 1'b0; m_locked = 1'b0;
      end else if (v) begin
         stray = (d > 7);
         good  = !stray && (d == nxt(m_ref));
         if (m_locked) begin
            if (good) begin
               m_ref = d; m_miss = 0;
            end else begin
               m_mism = 1'b1;
               m_err++;
               m_ref = nxt(m_ref);
               m_miss++;
               if (m_miss == 2) begin
                  m_locked = 1'b0; m_seeded = 1'b0; m_miss = 0; m_run = 0;
               end
            end
         end else if (!m_seeded) begin
            if (!stray) begin
               m_seeded = 1'b1; m_ref = d; m_run = 0;
            end
         end else if (stray) begin
            m_seeded = 1'b0; m_run = 0;
         end else if (good) begin
            m_ref = d; m_run++;
            if (m_run == 4) m_locked = 1'b1;
         end else begin
            m_ref = d; m_run = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("locked",   a_locked,   m_locked);
         chk("mismatch", a_mismatch, m_mism);
         chk("expected", a_expected, m_expected());
         chk("err_a",    a_err,      (m_err > 255) ? 255 : m_err);
         chk("err_b",    b_err,      (m_err > 3) ? 3 : m_err);
         chk("mismatch_b", b_mismatch, m_mism);
      end
   end

   task automatic step(input bit r, input bit v, input int d);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in_data  = d[3:0];
      @(posedge clk);
      model_step(r, v, d);
      #1;
   endtask

   task automatic lock_from(input int seed);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, (seed + i) % 8);
   endtask

   initial begin
      automatic int bad_v[5]  = '{0, 1, 5, 6, 0};
      automatic int good_v[5] = '{6, 0, 2, 4, 6};
      automatic int sat_v[5]  = '{1, 2, 3, 3, 3};

      // Reset state
      step(1'b1, 1'b1, 5);
      chk_en = 1'b1;
      chk("rst_locked", a_locked, 0);
      chk("rst_expected", a_expected, 0);
      chk("rst_err", a_err, 0);

      // Lock after reset
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i);
      chk("t1_not_locked_yet", a_locked, 0);
      chk("t1_expected_sync", a_expected, 4);
      step(1'b0, 1'b1, 4);
      chk("t1_locked", a_locked, 1);
      chk("t1_expected", a_expected, 5);
      chk("t1_err", a_err, 0);

      // Wrap-around
      step(1'b0, 1'b1, 5); step(1'b0, 1'b1, 6); step(1'b0, 1'b1, 7);
      step(1'b0, 1'b1, 0); step(1'b0, 1'b1, 1);
      chk("t2_locked", a_locked, 1);
      chk("t2_expected", a_expected, 2);

      // Single glitch, flywheel
      step(1'b0, 1'b1, 2);
      step(1'b0, 1'b1, 3);
      step(1'b0, 1'b1, 6);
      chk("t3_pulse", a_mismatch, 1);
      chk("t3_flywheel_exp", a_expected, 5);
      step(1'b0, 1'b1, 5);
      chk("t3_no_pulse", a_mismatch, 0);
      chk("t3_err", a_err, 1);
      chk("t3_locked", a_locked, 1);
      chk("t3_expected", a_expected, 6);

      // Stray bit and loss
      step(1'b1, 1'b0, 0);
      lock_from(7);
      chk("t4_locked_ref3", a_expected, 4);
      step(1'b0, 1'b1, 4'b1100);
      chk("t4_pulse1", a_mismatch, 1);
      chk("t4_err1", a_err, 1);
      chk("t4_still_locked", a_locked, 1);
      step(1'b0, 1'b1, 4'b0010);
      chk("t4_pulse2", a_mismatch, 1);
      chk("t4_err2", a_err, 2);
      chk("t4_lost", a_locked, 0);
      chk("t4_hunt_exp", a_expected, 0);
      step(1'b0, 1'b1, 3);
      chk("t4_seed_exp", a_expected, 4);

      // Gaps and reset mid-op
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 6);
      chk("t5_gap_hold", a_expected, 1);
      step(1'b0, 1'b1, 1);
      chk("t5_expected", a_expected, 2);
      step(1'b1, 1'b1, 2);
      chk("t5_rst_exp", a_expected, 0);
      chk("t5_rst_locked", a_locked, 0);
      chk("t5_rst_mismatch", a_mismatch, 0);
      chk("t5_rst_err", a_err, 0);
      step(1'b0, 1'b1, 2);
      chk("t5_reseed_exp", a_expected, 3);
      chk("t5_reseed_locked", a_locked, 0);

      // Saturation on the narrow counter
      step(1'b1, 1'b0, 0);
      lock_from(0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, bad_v[k]);
         chk("t6_pulse", b_mismatch, 1);
         chk("t6_sat_count", b_err, sat_v[k]);
         chk("t6_wide_count", a_err, k + 1);
         step(1'b0, 1'b1, good_v[k]);
         chk("t6_no_pulse", b_mismatch, 0);
         chk("t6_locked", b_locked, 1);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/nibble_seq_checker.md
# nibble_seq_checker

Receive-side checker for the masked nibble stream produced by the counter-plus-mask stimulus path. It samples a 4-bit data bus qualified by a valid strobe, acquires lock onto the expected masked incrementing sequence, and then flags every deviation. It reports lock status, a per-sample mismatch pulse and a saturating error count. It sits at the consuming end of the stream, opposite the source that increments a counter and masks it.

## Interface
- `WIDTH`, 4: data width.
- `MASK`, 4'b0111: mask applied by the source. Must be low-contiguous ones (2^k-1); any other value is illegal.
- `LOCK_COUNT`, 4: number of consecutive correct successors needed to lock; must be at least 1.
- `LOSS_COUNT`, 2: number of consecutive mismatches while locked that drop lock; must be at least 1.
- `ERR_W`, 8: width of the error counter.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `in_valid` input 1: `in_data` is sampled on a rising edge where this is high.
- `in_data` input WIDTH: received sample.
- `locked` output 1: checker is in LOCKED.
- `mismatch` output 1: one-cycle pulse for each bad sample received while locked.
- `err_count` output ERR_W: saturating count of mismatches while locked.
- `expected` output WIDTH: value predicted for the next sample; 0 unless the state is SYNC or LOCKED.

## Operation
- **Definitions**
  - `succ(x) = (x + 1) & MASK`. Wrap-around is implicit: for MASK 0111, 7 is followed by 0.
  - A sample is *stray* if `in_data & ~MASK != 0`.
  - A sample is *good* if it is not stray and equals `succ(ref)`.
- **Registers:** `ref` (WIDTH), `run` (holds 0..LOCK_COUNT), `miss` (holds 0..LOSS_COUNT), `state`.
- **State machine:** HUNT, SYNC, LOCKED. A transition happens only on an edge where `in_valid` is high; with `in_valid` low, all state is held.
- **HUNT**
  - Clean sample: set `ref <= in_data`, `run <= 0`, go to SYNC.
  - Stray sample: stay in HUNT.
- **SYNC**
  - Good sample: set `ref <= in_data`, `run <= run+1`. Go to LOCKED when `run+1 == LOCK_COUNT`.
  - Clean but not good: reseed with `ref <= in_data`, `run <= 0`, stay in SYNC.
  - Stray: go to HUNT with `run <= 0`.
- **LOCKED**
  - Good sample: `ref <= in_data`, `miss <= 0`.
  - Otherwise (including stray): this is a mismatch.
    - Assert the `mismatch` pulse and increment `err_count`.
    - Flywheel: `ref <= succ(ref)`, not `in_data`.
    - `miss <= miss+1`.
    - When `miss+1 == LOSS_COUNT`, go to HUNT with `miss <= 0` and `run <= 0`. `err_count` is kept.
- **Error counter**
  - Counts only mismatches in LOCKED.
  - Saturates at all-ones and never wraps.
  - Cleared only by `rst`.
- **Outputs**
  - `mismatch` is never asserted outside LOCKED.
  - `expected = succ(ref)` in SYNC and LOCKED, 0 in HUNT.

## Timing
- All outputs are registered.
- `mismatch` is high for exactly the one cycle after the edge that sampled the bad data.
- `locked` rises on the cycle after the edge that sampled the LOCK_COUNT-th good successor. It falls on the cycle after the edge that sampled the LOSS_COUNT-th consecutive mismatch; that same cycle also shows `mismatch` high.
- Back-to-back valid samples are supported with no throughput loss. Gaps (`in_valid` low) of any length are transparent: prediction does not advance during gaps.
- **Reset:** `state` = HUNT, `locked` = 0, `mismatch` = 0, `err_count` = 0, `expected` = 0, `ref` = 0, `run` = 0, `miss` = 0.
- Reset takes priority over a simultaneous `in_valid`. Reset asserted mid-stream discards lock and the count; the sample presented on the reset edge is ignored.
- When the error counter is saturated and a mismatch arrives, the pulse still fires and the count stays at max.

## Structure
- **Shared package `nibble_check_pkg`** holds:
  - the state encodings `ST_HUNT`, `ST_SYNC`, `ST_LOCKED`;
  - the default mask constant `NIBBLE_MASK = 4'b0111`;
  - a `succ` function.
- The stimulus side reuses `NIBBLE_MASK` from this package.
- **Sub-module `sat_counter`** (parameter W; ports `clk`, `rst`, `inc`, `count`) implements `err_count`. It is natural to reuse for other statistics.
- The FSM and compare logic are in the top level.

## Test plan
All scenarios use default parameters.
1. **Lock after reset:** after `rst`, send valid 0,1,2,3,4 back-to-back. `locked` = 0 through the 4th sample and goes to 1 the cycle after sample 4. `err_count` = 0 and `expected` = 5.
2. **Wrap-around:** once locked, send 5,6,7,0,1. There are no `mismatch` pulses and `locked` stays 1.
3. **Single glitch, flywheel:** locked with `ref` = 2, send 3,6,5. There is one `mismatch` pulse (on 6), `err_count` = 1 and `locked` stays 1. Value 5 matches because the flywheel advanced `ref` past 4.
4. **Stray bit and loss:** locked with `ref` = 3, send 4'b1100 then 4'b0010. Two `mismatch` pulses occur, `err_count` = 2, and `locked` falls after the second. The sample 2 does not seed SYNC.
5. **Gaps and reset mid-op:** send 0,1 with `in_valid` low for 10 cycles in between; the prediction holds and `expected` = 2. Assert `rst` together with a valid 2. All outputs return to their reset values and the next valid 2 only seeds SYNC.
6. **Saturation:** with `ERR_W` = 2 and locked, alternate good and bad samples for 5 bad samples. The count reads 1,2,3,3,3 and a `mismatch` pulse fires every time.
